// File: rtl/visor_rx_fifo_pkg.sv
// ---------------------------------------------------------------------------
// visor_rx_fifo_pkg
// Shared visor defines for the UART receive FIFO register. Contents:
//   - bit positions of the visor-readable status/data word
//   - bit indices of the visor load (control) word
//   - DR_ register addresses of the visor register map
//   - pack_rx_word(): assembles the 16-bit visor word from its fields
// ---------------------------------------------------------------------------
package visor_rx_fifo_pkg;

  // Visor-readable word layout
  localparam int VALID_BIT   = 15;
  localparam int OVERRUN_BIT = 14;
  localparam int COUNT_LSB   = 8;
  localparam int COUNT_W     = 6;
  localparam int HEAD_LSB    = 0;
  localparam int HEAD_W      = 8;

  // Visor load word bit indices
  localparam int CTRL_CLR_OVR_BIT = 0;
  localparam int CTRL_FLUSH_BIT   = 1;

  // Visor register addresses
  typedef enum logic [3:0] {
    DR_STATUS  = 4'h0,
    DR_TX_DATA = 4'h1,
    DR_RX_FIFO = 4'h2,
    DR_CTRL    = 4'h3
  } visor_dr_addr_e;

  function automatic logic [15:0] pack_rx_word(
    input logic               valid,
    input logic               overrun,
    input logic [COUNT_W-1:0] count,
    input logic [HEAD_W-1:0]  head
  );
    logic [15:0] word;
    word                           = '0;
    word[VALID_BIT]                = valid;
    word[OVERRUN_BIT]              = overrun;
    word[COUNT_LSB +: COUNT_W]     = count;
    word[HEAD_LSB +: HEAD_W]       = head;
    return word;
  endfunction

endpackage

// File: rtl/sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchronizer bringing a single-bit level from a foreign clock
// domain into sysclk. Both flops clear asynchronously on sysreset.
// Ports:
//   sysclk   - destination clock
//   sysreset - asynchronous, active-high reset
//   d_i      - asynchronous input level
//   q_o      - synchronized level (two sysclk cycles of latency)
// ---------------------------------------------------------------------------
module sync2 (
  input  logic sysclk,
  input  logic sysreset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/visor_rx_fifo.sv
// ---------------------------------------------------------------------------
// visor_rx_fifo
// Receive FIFO between uart_v2_rx and the visor register interface. A byte
// is captured when the (synchronized) rx_busy flag falls, and pushed into a
// DEPTH-entry FIFO. The visor reads the head byte plus status through
// reg_out and pops with rd_strobe; a visor load clears overrun / flushes.
// Ports:
//   sysclk     - system clock
//   sysreset   - asynchronous, active-high reset
//   rx_busy    - byte-in-progress flag (clk_async domain)
//   rx_data    - received byte, stable after rx_busy falls
//   rd_strobe  - visor read pulse, pops the head byte
//   ctrl_load  - visor load pulse
//   ctrl_data  - load data: bit0 clears overrun, bit1 flushes
//   reg_out    - {valid, overrun, count[5:0], head[7:0]}
//   rx_avail   - FIFO not empty
// ---------------------------------------------------------------------------
module visor_rx_fifo
  import visor_rx_fifo_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        rx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rd_strobe,
  input  logic        ctrl_load,
  input  logic [1:0]  ctrl_data,
  output logic [15:0] reg_out,
  output logic        rx_avail
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // -------------------------------------------------------------------------
  // Byte-complete detection and capture
  // -------------------------------------------------------------------------
  logic       busy_sync;
  logic       hist_q;
  logic       byte_done;
  logic [7:0] cap_data_q;
  logic       cap_valid_q;

  sync2 u_busy_sync (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .d_i      (rx_busy),
    .q_o      (busy_sync)
  );

  // Falling edge of the synchronized busy flag. Since the history flop
  // clears on reset, a byte already in progress at reset release is seen
  // rising first and then captured normally when it falls.
  assign byte_done = hist_q & ~busy_sync;

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      hist_q      <= 1'b0;
      cap_data_q  <= 8'h00;
      cap_valid_q <= 1'b0;
    end else begin
      hist_q      <= busy_sync;
      cap_valid_q <= byte_done;
      if (byte_done) begin
        cap_data_q <= rx_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FIFO core
  // -------------------------------------------------------------------------
  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;

  logic empty;
  logic full;
  logic flush;
  logic clr_ovr;
  logic do_pop;
  logic do_push;
  logic drop;
  logic mem_we;
  logic [7:0] head;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign flush   = ctrl_load & ctrl_data[CTRL_FLUSH_BIT];
  assign clr_ovr = ctrl_load & ctrl_data[CTRL_CLR_OVR_BIT];

  // A pop frees the slot the same edge, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign do_pop  = rd_strobe & ~empty & ~flush;
  assign do_push = cap_valid_q & (~full | do_pop) & ~flush;
  assign drop    = cap_valid_q & full & ~do_pop & ~flush;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    mem_we    = 1'b0;

    if (flush) begin
      // Flush wins over any coincident push or pop.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      if (clr_ovr) begin
        overrun_d = 1'b0;
      end
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (do_push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // A dropped byte beats a coincident clear.
      if (drop) begin
        overrun_d = 1'b1;
      end else if (clr_ovr) begin
        overrun_d = 1'b0;
      end
    end
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage is deliberately not reset; mem_we cannot fire during reset
  // because cap_valid_q is held clear.
  always_ff @(posedge sysclk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= cap_data_q;
    end
  end

  // -------------------------------------------------------------------------
  // Visor-facing outputs
  // -------------------------------------------------------------------------
  assign head     = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign reg_out  = pack_rx_word(~empty, overrun_q, COUNT_W'(count_q), head);
  assign rx_avail = ~empty;

endmodule

// File: tb/tb_visor_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_visor_rx_fifo
// Directed stimulus for visor_rx_fifo. Bytes expected to enter the FIFO are
// queued by the stimulus; a monitor pops and compares on every read that
// the DUT presents valid data for. Status words are hand-computed.
// ---------------------------------------------------------------------------
module tb_visor_rx_fifo;

  logic        sysclk    = 1'b0;
  logic        sysreset  = 1'b1;
  logic        rx_busy   = 1'b0;
  logic [7:0]  rx_data   = 8'h00;
  logic        rd_strobe = 1'b0;
  logic        ctrl_load = 1'b0;
  logic [1:0]  ctrl_data = 2'b00;
  logic [15:0] reg_out;
  logic        rx_avail;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 sysclk = ~sysclk;

  visor_rx_fifo #(.DEPTH(16)) dut (
    .sysclk    (sysclk),
    .sysreset  (sysreset),
    .rx_busy   (rx_busy),
    .rx_data   (rx_data),
    .rd_strobe (rd_strobe),
    .ctrl_load (ctrl_load),
    .ctrl_data (ctrl_data),
    .reg_out   (reg_out),
    .rx_avail  (rx_avail)
  );

  // Scoreboard monitor: every read of a valid head byte is one transaction.
  always @(negedge sysclk) begin
    if (!sysreset && rd_strobe && reg_out[15]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL read_data: got %02h, expected no data", reg_out[7:0]);
      end else begin
        mon_exp = exp_q.pop_front();
        if (reg_out[7:0] !== mon_exp) begin
          errors++;
          $display("FAIL read_data: got %02h, expected %02h", reg_out[7:0], mon_exp);
        end else begin
          $display("read: got %02h expected %02h", reg_out[7:0], mon_exp);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic chk_word(input string name, input logic [15:0] exp);
    @(negedge sysclk);
    checks++;
    if (reg_out !== exp || rx_avail !== exp[15]) begin
      errors++;
      $display("FAIL %s: reg_out=%04h rx_avail=%b, expected reg_out=%04h rx_avail=%b",
               name, reg_out, rx_avail, exp, exp[15]);
    end else begin
      $display("check %s: reg_out=%04h rx_avail=%b", name, reg_out, rx_avail);
    end
  endtask

  // Full byte on the UART side: busy high, then fall, then wait for the
  // 4-cycle capture/push latency.
  task automatic send(input logic [7:0] b, input bit accepted);
    rx_data = b;
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0;
    tick(4);
    if (accepted) exp_q.push_back(b);
  endtask

  task automatic rd_n(input int n);
    repeat (n) begin
      rd_strobe = 1'b1;
      tick(1);
      rd_strobe = 1'b0;
    end
  endtask

  task automatic ctrl(input logic [1:0] d);
    ctrl_load = 1'b1;
    ctrl_data = d;
    tick(1);
    ctrl_load = 1'b0;
    ctrl_data = 2'b00;
  endtask

  initial begin
    // Reset state
    tick(3);
    sysreset = 1'b0;
    chk_word("reset", 16'h0000);

    // Single byte with latency boundary
    rx_data = 8'hA5;
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0;
    tick(3);
    chk_word("single_3cyc", 16'h0000);
    tick(1);
    exp_q.push_back(8'hA5);
    chk_word("single_4cyc", 16'h81A5);
    rd_n(1);
    chk_word("single_read", 16'h0000);

    // Read while empty has no effect
    rd_n(1);
    chk_word("empty_read", 16'h0000);

    // Fill to full, then overflow
    for (int i = 0; i < 16; i++) send(8'(i), 1'b1);
    chk_word("full", 16'h9000);
    send(8'hFF, 1'b0);
    chk_word("overflow", 16'hD000);
    rd_n(16);
    chk_word("drained_ovr", 16'h4000);

    // Control: clear overrun only, no-op load, flush
    for (int i = 0; i < 5; i++) send(8'h20 + 8'(i), 1'b1);
    chk_word("five_ovr", 16'hC520);
    ctrl(2'b01);
    chk_word("clr_ovr", 16'h8520);
    ctrl(2'b00);
    chk_word("ctrl_noop", 16'h8520);
    ctrl(2'b10);
    exp_q.delete();
    chk_word("flush", 16'h0000);

    // Wrap-around across index 15 -> 0
    for (int i = 0; i < 10; i++) send(8'h40 + 8'(i), 1'b1);
    rd_n(10);
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i), 1'b1);
    chk_word("wrap_fill", 16'h8A30);
    rd_n(10);
    chk_word("wrap_drain", 16'h0000);

    // Full FIFO: push coincident with pop
    for (int i = 0; i < 16; i++) send(8'h50 + 8'(i), 1'b1);
    rx_data = 8'h60;
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0;
    tick(3);
    rd_strobe = 1'b1;
    tick(1);
    rd_strobe = 1'b0;
    exp_q.push_back(8'h60);
    chk_word("push_pop_full", 16'h9051);

    // Full FIFO: dropped byte coincident with clear -> overrun set
    rx_data = 8'h61;
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0;
    tick(3);
    ctrl_load = 1'b1;
    ctrl_data = 2'b01;
    tick(1);
    ctrl_load = 1'b0;
    ctrl_data = 2'b00;
    chk_word("drop_vs_clr", 16'hD051);
    ctrl(2'b01);
    chk_word("clr_after", 16'h9051);
    rd_n(16);
    chk_word("drain2", 16'h0000);

    // Push coincident with flush is discarded without overrun
    rx_data = 8'h66;
    rx_busy = 1'b1;
    tick(3);
    rx_busy = 1'b0;
    tick(3);
    ctrl_load = 1'b1;
    ctrl_data = 2'b10;
    tick(1);
    ctrl_load = 1'b0;
    ctrl_data = 2'b00;
    chk_word("push_vs_flush", 16'h0000);

    // Reset mid-operation with a byte in progress
    for (int i = 0; i < 3; i++) send(8'h70 + 8'(i), 1'b1);
    chk_word("three", 16'h8370);
    rx_data = 8'hEE;
    rx_busy = 1'b1;
    tick(2);
    sysreset = 1'b1;
    exp_q.delete();
    chk_word("in_reset", 16'h0000);
    tick(1);
    sysreset = 1'b0;
    chk_word("after_reset", 16'h0000);
    rx_data = 8'h5A;
    tick(3);
    rx_busy = 1'b0;
    tick(4);
    exp_q.push_back(8'h5A);
    chk_word("post_reset_byte", 16'h815A);
    rd_n(1);
    chk_word("final", 16'h0000);

    // Every expected byte must have been read back
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d bytes left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/visor_rx_fifo.md
VISOR_RX_FIFO -- requirements
Module: visor_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, meaning FIFO capacity in bytes; legal values are powers of two from 2 to 32.
REQ-002 sysclk  input  1  system clock; all state is sampled on its rising edge.
REQ-003 sysreset  input  1  asynchronous, active-high reset.
REQ-004 rx_busy  input  1  byte-in-progress flag from uart_v2_rx, in the clk_async domain.
REQ-005 rx_data  input  8  received byte from uart_v2_rx; held stable from the rx_busy fall until the next start bit (at least 4 clk_async periods).
REQ-006 rd_strobe  input  1  visor read pulse for this register (vr_read); pops the head byte.
REQ-007 ctrl_load  input  1  visor load pulse for this register (vr_load).
REQ-008 ctrl_data  input  2  visor load data [1:0]; bit0 clears overrun, bit1 flushes the FIFO.
REQ-009 reg_out  output  16  visor-readable word: [15] valid, [14] overrun, [13:8] count, [7:0] head byte.
REQ-010 rx_avail  output  1  high whenever count is nonzero.

Function
REQ-011 rx_busy passes through a 2-flop synchronizer into sysclk, followed by one edge-history flop.
REQ-012 A byte-complete event fires on the first sysclk cycle where the synced value is 0 and the history flop is 1.
REQ-013 On a byte-complete event, rx_data is registered and pushed one cycle later; total latency from rx_busy fall is 4 sysclk cycles.
REQ-014 Storage is a DEPTH-entry array with write pointer and read pointer of log2(DEPTH) bits each, plus a separate count of log2(DEPTH)+1 bits.
REQ-015 Pointers wrap modulo DEPTH with no gap.
REQ-016 reg_out[7:0] shows the head entry combinationally when valid, and 8'h00 when empty.
REQ-017 reg_out[15] equals (count != 0).
REQ-018 reg_out[13:8] equals count, zero-extended.
REQ-019 rd_strobe while nonempty advances the read pointer and decrements count on the same edge.
REQ-020 rd_strobe while empty has no effect.
REQ-021 A push while not full writes at the write pointer, then increments the write pointer and count.
REQ-022 A push while full drops the byte and sets overrun; stored data and pointers are unchanged.
REQ-023 Push and pop on the same edge both take effect, leaving count unchanged; when full, that push is accepted.
REQ-024 Overrun is sticky until ctrl_load with ctrl_data[0]=1.
REQ-025 If an overrun-setting drop and a clear coincide, overrun ends set (set wins).
REQ-026 ctrl_load with ctrl_data[1]=1 zeroes both pointers and count on that edge.
REQ-027 A push coinciding with a flush is discarded; it does not set overrun.
REQ-028 Any pop coinciding with a flush is ignored.
REQ-029 ctrl_load with ctrl_data=2'b00 has no effect.

Reset
REQ-030 sysreset asynchronously clears pointers, count, overrun, synchronizer and history flops, and the capture register.
REQ-031 After reset, reg_out=16'h0000 and rx_avail=0.
REQ-032 Storage array contents are not reset.
REQ-033 A byte in progress when reset releases, with rx_busy high, is captured normally on its fall.
REQ-034 Reset asserted mid-push aborts that push, with no partial state afterwards.

Structure
REQ-035 Bit positions VALID_BIT=15, OVERRUN_BIT=14, COUNT_LSB=8 and the ctrl bit indices live in the shared visor defines package, alongside the DR_ register addresses.
REQ-036 One sub-module, sync2 (2-flop synchronizer with asynchronous reset), is instantiated for rx_busy.
REQ-037 The FIFO core stays inline.

Verification
REQ-038 Single byte: rx_busy pulse with rx_data=8'hA5 -> reg_out=16'h81A5 four cycles after the fall; one rd_strobe -> 16'h0000.
REQ-039 Fill to full: push 16 bytes 8'h00..8'h0F -> count=16, head 8'h00; 17th byte 8'hFF -> overrun=1, count=16; 16 reads return 8'h00..8'h0F in order.
REQ-040 Wrap-around: push 10, pop 10, push 10 (8'h30..8'h39) -> reads return 8'h30..8'h39 in order and pointers cross index 15->0 correctly.
REQ-041 Simultaneous events: full FIFO, push coincident with rd_strobe -> count stays 16, overrun stays 0, new byte at tail.
REQ-042 Control: with overrun set, ctrl_data=2'b01 clears overrun only; with 5 entries, ctrl_data=2'b10 -> reg_out=16'h0000 (overrun unchanged).
REQ-043 Reset mid-operation: assert sysreset with 3 entries and rx_busy high, release it -> reg_out=16'h0000; the subsequent rx_busy fall with 8'h5A -> reg_out=16'h815A.
